decode_sequencer: RTL

- Front-end decode controller between the fetch queue and rename/dispatch.
- Accepts 16-bit Thumb halfwords with a valid/ready handshake and drives the microcode ROM address.
- Registers the ROM output into a one-entry issue buffer.
- Sequences the two-halfword BL pair (prefix 11110, suffix 11111) into a single issued micro-op.
- Handles back-pressure and pipeline flush.

---
 rtl/decode_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - Thumb halfword decode sequencer with one-entry issue buffer
//
// Purpose: accepts 16-bit Thumb halfwords from the fetch queue, addresses the
// microcode ROM, and registers the ROM word into a one-entry issue buffer.
// The BL prefix (11110) / suffix (11111) pair is fused into one micro-op; a
// prefix followed by anything else issues an illegal NOOP.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   flush_i                 squash issue buffer and any held prefix
//   fetch_v_i/_instr_i/_pc_i, fetch_ready_o   fetch handshake
//   rom_addr_o, rom_data_i  combinational microcode ROM lookup
//   issue_v_o/_ucode_o/_instr_o/_pc_o/_illegal_o, issue_ready_i   issue handshake
//
// Optional: define DECODE_PERF_EN to add perf_issued_o, perf_stall_o and
// perf_illegal_o event counters (not cleared by flush_i).
module decode_sequencer #(
    parameter int UCODE_WIDTH_P = 32,
    parameter int INPUT_WIDTH_P = 10,
    parameter int PC_WIDTH_P    = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     fetch_v_i,
    input  logic [15:0]              fetch_instr_i,
    input  logic [PC_WIDTH_P-1:0]    fetch_pc_i,
    output logic                     fetch_ready_o,
    output logic [INPUT_WIDTH_P-1:0] rom_addr_o,
    input  logic [UCODE_WIDTH_P-1:0] rom_data_i,
    output logic                     issue_v_o,
    output logic [UCODE_WIDTH_P-1:0] issue_ucode_o,
    output logic [31:0]              issue_instr_o,
    output logic [PC_WIDTH_P-1:0]    issue_pc_o,
    output logic                     issue_illegal_o,
    input  logic                     issue_ready_i
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]              perf_issued_o,
    output logic [31:0]              perf_stall_o,
    output logic [15:0]              perf_illegal_o
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        PREFIX = 1'b1
    } state_t;

    state_t state, state_n;

    logic [15:0]              pfx_instr;
    logic [PC_WIDTH_P-1:0]    pfx_pc;

    logic                     space;
    logic                     accept;
    logic                     is_prefix;
    logic                     is_suffix;

    logic                     load;
    logic                     pfx_capture;
    logic [UCODE_WIDTH_P-1:0] load_ucode;
    logic [31:0]              load_instr;
    logic [PC_WIDTH_P-1:0]    load_pc;
    logic                     load_illegal;

    // The buffer has room when empty or when its current entry leaves this cycle.
    assign space         = !issue_v_o | issue_ready_i;
    assign fetch_ready_o = space & !flush_i & !reset_i;
    assign accept        = fetch_v_i & fetch_ready_o;
    assign is_prefix     = (fetch_instr_i[15:11] == 5'b11110);
    assign is_suffix     = (fetch_instr_i[15:11] == 5'b11111);

    // While a prefix is held the ROM is addressed by the prefix, so the suffix
    // cycle picks up the BL micro-op rather than the suffix's own encoding.
    assign rom_addr_o = (state == PREFIX) ? pfx_instr[15:16-INPUT_WIDTH_P]
                                          : fetch_instr_i[15:16-INPUT_WIDTH_P];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        load         = 1'b0;
        pfx_capture  = 1'b0;
        load_ucode   = rom_data_i;
        load_instr   = {16'h0000, fetch_instr_i};
        load_pc      = fetch_pc_i;
        load_illegal = 1'b0;
        if (flush_i) begin
            state_n = IDLE;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (is_prefix) begin
                        pfx_capture = 1'b1;
                        state_n     = PREFIX;
                    end else begin
                        load = 1'b1;
                    end
                end
                PREFIX: begin
                    load       = 1'b1;
                    load_instr = {pfx_instr, fetch_instr_i};
                    load_pc    = pfx_pc;
                    state_n    = IDLE;
                    // Broken pair: the second halfword is consumed as part of
                    // the pair and issued as a NOOP flagged illegal.
                    if (!is_suffix) begin
                        load_ucode   = '0;
                        load_illegal = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            issue_v_o       <= 1'b0;
            issue_ucode_o   <= '0;
            issue_instr_o   <= '0;
            issue_pc_o      <= '0;
            issue_illegal_o <= 1'b0;
            pfx_instr       <= '0;
            pfx_pc          <= '0;
        end else if (flush_i) begin
            issue_v_o <= 1'b0;
            pfx_instr <= '0;
            pfx_pc    <= '0;
        end else begin
            if (load) begin
                issue_v_o       <= 1'b1;
                issue_ucode_o   <= load_ucode;
                issue_instr_o   <= load_instr;
                issue_pc_o      <= load_pc;
                issue_illegal_o <= load_illegal;
            end else if (issue_ready_i) begin
                issue_v_o <= 1'b0;
            end
            if (pfx_capture) begin
                pfx_instr <= fetch_instr_i;
                pfx_pc    <= fetch_pc_i;
            end
        end
    end

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_issued_o  <= '0;
            perf_stall_o   <= '0;
            perf_illegal_o <= '0;
        end else begin
            if (issue_v_o & issue_ready_i) begin
                perf_issued_o <= perf_issued_o + 32'd1;
                if (issue_illegal_o) begin
                    perf_illegal_o <= perf_illegal_o + 16'd1;
                end
            end
            if (issue_v_o & !issue_ready_i) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule
